// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle restoring divider: state encoding,
// iteration bound, divide-by-zero quotient and an absolute-value helper.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

  localparam logic [4:0]  ITER_LAST        = 5'd31;
  localparam logic [31:0] DBZ_QUOT_DEFAULT = 32'hFFFF_FFFF;

  // Two's complement magnitude; 0x80000000 maps to itself, which the unsigned path handles.
  function automatic logic [31:0] absVal(input logic [31:0] a);
    return a[31] ? (~a + 32'd1) : a;
  endfunction

endpackage

// File: rtl/div_sequencer_subtract.sv
// Fixed-width 32-bit subtractor used as the divider's iteration datapath.
// cout is high when no borrow occurs, i.e. a >= b as unsigned values.
module subtract_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        cout
);

  logic [32:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign diff  = w_sum[31:0];
  assign cout  = w_sum[32];

endmodule

// File: rtl/div_sequencer.sv
// Restoring divider controller for MIPS DIV/DIVU: one shared subtractor stepped
// over 32 shift/subtract iterations, then a sign/divide-by-zero fix-up cycle.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] DBZ_QUOT = DBZ_QUOT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  divState_t   r_state;
  divState_t   w_nextState;

  logic [31:0] r_qReg;
  logic [31:0] r_dReg;
  logic [31:0] r_rReg;
  logic [31:0] r_dividend;
  logic [4:0]  r_count;
  logic        r_negQ;
  logic        r_negR;
  logic        r_dbz;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_dbzOut;

  logic [31:0] w_shift;
  logic [31:0] w_diff;
  logic        w_cout;
  logic        w_take;

  // A set R[31] means the true shifted value exceeds 32 bits, so it is always >= D.
  assign w_shift = {r_rReg[30:0], r_qReg[31]};
  assign w_take  = r_rReg[31] | w_cout;

  subtract_32_bit u_subtract (
    .a    (w_shift),
    .b    (r_dReg),
    .diff (w_diff),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (r_count == ITER_LAST) w_nextState = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_qReg      <= '0;
      r_dReg      <= '0;
      r_rReg      <= '0;
      r_dividend  <= '0;
      r_count     <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbzOut    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_qReg     <= is_signed ? absVal(dividend) : dividend;
            r_dReg     <= is_signed ? absVal(divisor) : divisor;
            r_rReg     <= '0;
            r_count    <= '0;
            r_dividend <= dividend;
            r_negQ     <= is_signed & (dividend[31] ^ divisor[31]);
            r_negR     <= is_signed & dividend[31];
            r_dbz      <= (divisor == 32'd0);
            r_dbzOut   <= 1'b0;
          end
        end
        ITER: begin
          r_rReg  <= w_take ? w_diff : w_shift;
          r_qReg  <= {r_qReg[30:0], w_take};
          r_count <= r_count + 5'd1;
        end
        FIX: begin
          if (r_dbz) begin
            r_quotient  <= DBZ_QUOT;
            r_remainder <= r_dividend;
            r_dbzOut    <= 1'b1;
          end else begin
            r_quotient  <= r_negQ ? (~r_qReg + 32'd1) : r_qReg;
            r_remainder <= r_negR ? (~r_rReg + 32'd1) : r_rReg;
            r_dbzOut    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbzOut;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random
// operands compared against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checkCount;
  int failCount;

  logic [31:0] obsQ;
  logic [31:0] obsR;
  logic        obsZ;
  int          obsBusy;
  int          obsDoneAt;
  logic        obsDoneAfter;

  localparam int DONE_CYCLE = 33;
  localparam int BUSY_CYCLES = 33;

  div_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; SV / and % on signed values truncate toward zero.
  task automatic refModel(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end
  endtask

  // Launches one division and samples every cycle (on the falling edge) until done.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit s,
                               input bit holdStart);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
    if (holdStart) begin
      dividend = ~a;
      divisor  = b + 32'd1;
    end
    obsBusy   = 0;
    obsDoneAt = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) obsBusy++;
      if (done) begin
        obsDoneAt = k;
        obsQ      = quotient;
        obsR      = remainder;
        obsZ      = div_by_zero;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    obsDoneAfter = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      failCount++;
      $display("[TB] FAIL reset_state: busy=%b done=%b q=%h r=%h dbz=%b, required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] tA [9];
    logic [31:0] tB [9];
    bit          tS [9];
    logic [31:0] eQ;
    logic [31:0] eR;
    logic        eZ;
    tA = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'd5, 32'd5, 32'd9, 32'h8000_0000};
    tB = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'h8000_0000,
           32'd0, 32'd0, 32'd3, 32'hFFFF_FFFF};
    tS = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tA[i], tB[i], tS[i], 1'b0);
      refModel(tA[i], tB[i], tS[i], eQ, eR, eZ);
      checkCount++;
      if (obsDoneAt !== DONE_CYCLE) begin
        failCount++;
        $display("[TB] FAIL latency_%0d: done seen in cycle after edge %0d, required %0d",
                 i, obsDoneAt, DONE_CYCLE);
      end
      checkCount++;
      if (obsBusy !== BUSY_CYCLES) begin
        failCount++;
        $display("[TB] FAIL busy_len_%0d: busy cycles %0d, required %0d", i, obsBusy, BUSY_CYCLES);
      end
      checkCount++;
      if (obsDoneAfter !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL done_pulse_%0d: done still high after one cycle", i);
      end
      checkCount++;
      if ({obsQ, obsR, obsZ} !== {eQ, eR, eZ}) begin
        failCount++;
        $display("[TB] FAIL result_%0d: %h/%h s=%0d got q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, tA[i], tB[i], tS[i], obsQ, obsR, obsZ, eQ, eR, eZ);
      end
    end
    // Spot-check a few values that are written out directly rather than modelled.
    checkCount++;
    if ({quotient, remainder} !== {32'h8000_0000, 32'd0}) begin
      failCount++;
      $display("[TB] FAIL min_by_neg1: q=%h r=%h, required q=80000000 r=00000000", quotient, remainder);
    end
  endtask

  task automatic test_start_held();
    logic [31:0] eQ;
    logic [31:0] eR;
    logic        eZ;
    applyStimulus(32'd1000, 32'd33, 1'b0, 1'b1);
    refModel(32'd1000, 32'd33, 1'b0, eQ, eR, eZ);
    checkCount++;
    if ({obsQ, obsR, obsZ} !== {32'd30, 32'd10, 1'b0} || {eQ, eR} !== {32'd30, 32'd10}) begin
      failCount++;
      $display("[TB] FAIL start_held: got q=%0d r=%0d dbz=%b, required q=30 r=10 dbz=0",
               obsQ, obsR, obsZ);
    end
    checkCount++;
    if (obsDoneAt !== DONE_CYCLE || obsBusy !== BUSY_CYCLES) begin
      failCount++;
      $display("[TB] FAIL start_held_timing: done at %0d busy %0d, required %0d and %0d",
               obsDoneAt, obsBusy, DONE_CYCLE, BUSY_CYCLES);
    end
  endtask

  task automatic test_reset_mid_op();
    int sawDone;
    @(negedge clk);
    dividend  = 32'd12345;
    divisor   = 32'd17;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      failCount++;
      $display("[TB] FAIL reset_mid_op: busy=%b done=%b q=%h r=%h dbz=%b, required all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
    sawDone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) sawDone++;
    end
    checkCount++;
    if (sawDone !== 0) begin
      failCount++;
      $display("[TB] FAIL abort_no_done: %0d cycles of busy/done after reset, required 0", sawDone);
    end
    applyStimulus(32'd20, 32'd6, 1'b0, 1'b0);
    checkCount++;
    if ({obsQ, obsR, obsZ} !== {32'd3, 32'd2, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL after_reset_20_6: got q=%0d r=%0d dbz=%b, required q=3 r=2 dbz=0",
               obsQ, obsR, obsZ);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] eQ;
    logic [31:0] eR;
    logic        eZ;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = 32'($urandom) >> $urandom_range(0, 31);
        2:       b = -32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      applyStimulus(a, b, s, 1'b0);
      refModel(a, b, s, eQ, eR, eZ);
      checkCount++;
      if (obsDoneAt !== DONE_CYCLE || {obsQ, obsR, obsZ} !== {eQ, eR, eZ}) begin
        failCount++;
        $display("[TB] FAIL random_%0d: %h/%h s=%0d got q=%h r=%h dbz=%b at %0d, required q=%h r=%h dbz=%b at %0d",
                 i, a, b, s, obsQ, obsR, obsZ, obsDoneAt, eQ, eR, eZ, DONE_CYCLE);
      end
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
